// File: rtl/me_frame_scheduler_pkg.sv
// Shared encodings and default widths for the motion-estimation frame scheduler.
// Pure declarations; no latency or flow control.
package me_frame_scheduler_pkg;

  localparam int SAD_W     = 16;
  localparam int MV_W      = 7;
  localparam int MB_W      = 8;
  localparam int BASE_W    = 16;
  // One 16x16 block of 8-bit pixels is 32 words of 64 bits.
  localparam int CUR_SHIFT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPORT,
    S_NEXT,
    S_FDONE
  } state_t;

endpackage

// File: rtl/me_frame_scheduler_best_tracker.sv
// Running minimum SAD and its motion vector; next-best is combinational, state updates each clock.
// Strict less-than keeps the earliest candidate on ties; init overrides any candidate.
module me_best_tracker #(
  parameter int SAD_W = me_frame_scheduler_pkg::SAD_W,
  parameter int MV_W  = me_frame_scheduler_pkg::MV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [MV_W-1:0]  sad_mvx,
  input  logic [MV_W-1:0]  sad_mvy,
  output logic [SAD_W-1:0] nxt_sad,
  output logic [MV_W-1:0]  nxt_mvx,
  output logic [MV_W-1:0]  nxt_mvy
);

  logic [SAD_W-1:0] r_best_sad;
  logic [MV_W-1:0]  r_best_mvx;
  logic [MV_W-1:0]  r_best_mvy;

  always_comb begin
    nxt_sad = r_best_sad;
    nxt_mvx = r_best_mvx;
    nxt_mvy = r_best_mvy;
    if (init) begin
      nxt_sad = '1;
      nxt_mvx = '0;
      nxt_mvy = '0;
    end else if (sad_valid && (sad_value < r_best_sad)) begin
      nxt_sad = sad_value;
      nxt_mvx = sad_mvx;
      nxt_mvy = sad_mvy;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_sad <= '1;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else begin
      r_best_sad <= nxt_sad;
      r_best_mvx <= nxt_mvx;
      r_best_mvy <= nxt_mvy;
    end
  end

endmodule

// File: rtl/me_frame_scheduler.sv
// Walks a frame per macroblock, launches one search each, reports best SAD/MV over valid/ready.
// Overhead 3 cycles per macroblock plus res_ready stall; ME_SCHED_STATS_EN adds frame_sad/mb_count.
module me_frame_scheduler #(
  parameter int max_r = 2,
  parameter int SAD_W = me_frame_scheduler_pkg::SAD_W,
  parameter int MV_W  = me_frame_scheduler_pkg::MV_W,
  parameter int MB_W  = me_frame_scheduler_pkg::MB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [MB_W-1:0]  mb_cols,
  input  logic [MB_W-1:0]  mb_rows,
  input  logic [max_r-1:0] r_cfg,
  output logic             me_go,
  output logic [max_r-1:0] me_r,
  output logic [15:0]      cur_base,
  input  logic             me_done,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [MV_W-1:0]  sad_mvx,
  input  logic [MV_W-1:0]  sad_mvy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [MB_W-1:0]  res_mbx,
  output logic [MB_W-1:0]  res_mby,
  output logic [SAD_W-1:0] res_sad,
  output logic [MV_W-1:0]  res_mvx,
  output logic [MV_W-1:0]  res_mvy,
  output logic             busy,
  output logic             frame_done
`ifdef ME_SCHED_STATS_EN
  ,
  output logic [SAD_W+15:0] frame_sad,
  output logic [15:0]       mb_count
`endif
);
  import me_frame_scheduler_pkg::*;

  state_t           r_state;
  logic [MB_W-1:0]  r_cols, r_rows, r_mbx, r_mby;
  logic [max_r-1:0] r_range;
  logic             r_me_go, r_busy, r_frame_done, r_res_valid;
  logic [MB_W-1:0]  r_res_mbx, r_res_mby;
  logic [SAD_W-1:0] r_res_sad;
  logic [MV_W-1:0]  r_res_mvx, r_res_mvy;

  logic             w_hs, w_last_col, w_last_row;
  logic [31:0]      w_lin;
  logic [SAD_W-1:0] w_nxt_sad;
  logic [MV_W-1:0]  w_nxt_mvx, w_nxt_mvy;

  assign w_hs       = r_res_valid & res_ready;
  assign w_last_col = (r_mbx == r_cols - MB_W'(1));
  assign w_last_row = (r_mby == r_rows - MB_W'(1));
  assign w_lin      = 32'(r_mby) * 32'(r_cols) + 32'(r_mbx);

  me_best_tracker #(
    .SAD_W(SAD_W),
    .MV_W (MV_W)
  ) u_best (
    .clk      (clk),
    .reset    (reset),
    .init     (r_state == S_LAUNCH),
    .sad_valid(sad_valid && (r_state == S_WAIT)),
    .sad_value(sad_value),
    .sad_mvx  (sad_mvx),
    .sad_mvy  (sad_mvy),
    .nxt_sad  (w_nxt_sad),
    .nxt_mvx  (w_nxt_mvx),
    .nxt_mvy  (w_nxt_mvy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cols       <= '0;
      r_rows       <= '0;
      r_mbx        <= '0;
      r_mby        <= '0;
      r_range      <= '0;
      r_me_go      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_mbx    <= '0;
      r_res_mby    <= '0;
      r_res_sad    <= '1;
      r_res_mvx    <= '0;
      r_res_mvy    <= '0;
    end else begin
      r_me_go      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_cols  <= mb_cols;
            r_rows  <= mb_rows;
            r_range <= r_cfg;
            r_mbx   <= '0;
            r_mby   <= '0;
            r_busy  <= 1'b1;
            if ((mb_cols == '0) || (mb_rows == '0)) begin
              r_state      <= S_FDONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_LAUNCH;
              r_me_go <= 1'b1;
            end
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          // A candidate arriving with me_done is already folded into w_nxt_*.
          if (me_done) begin
            r_state     <= S_REPORT;
            r_res_valid <= 1'b1;
            r_res_mbx   <= r_mbx;
            r_res_mby   <= r_mby;
            r_res_sad   <= w_nxt_sad;
            r_res_mvx   <= w_nxt_mvx;
            r_res_mvy   <= w_nxt_mvy;
          end
        end
        S_REPORT: begin
          if (w_hs) begin
            r_res_valid <= 1'b0;
            if (w_last_col && w_last_row) begin
              r_state      <= S_FDONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (w_last_col) begin
            r_mbx <= '0;
            r_mby <= r_mby + MB_W'(1);
          end else begin
            r_mbx <= r_mbx + MB_W'(1);
          end
          r_state <= S_LAUNCH;
          r_me_go <= 1'b1;
        end
        S_FDONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign me_go      = r_me_go;
  assign me_r       = r_range;
  assign cur_base   = 16'(w_lin << CUR_SHIFT);
  assign res_valid  = r_res_valid;
  assign res_mbx    = r_res_mbx;
  assign res_mby    = r_res_mby;
  assign res_sad    = r_res_sad;
  assign res_mvx    = r_res_mvx;
  assign res_mvy    = r_res_mvy;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

`ifdef ME_SCHED_STATS_EN
  logic [SAD_W+15:0] r_frame_sad;
  logic [15:0]       r_mb_count;
  logic [SAD_W+16:0] w_sum;

  assign w_sum = {1'b0, r_frame_sad} + (SAD_W+17)'(r_res_sad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_sad <= '0;
      r_mb_count  <= '0;
    end else if ((r_state == S_IDLE) && frame_start) begin
      r_frame_sad <= '0;
      r_mb_count  <= '0;
    end else if (w_hs) begin
      r_frame_sad <= w_sum[SAD_W+16] ? '1 : w_sum[SAD_W+15:0];
      r_mb_count  <= r_mb_count + 16'd1;
    end
  end

  assign frame_sad = r_frame_sad;
  assign mb_count  = r_mb_count;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Self-checking bench for me_frame_scheduler: table of frame vectors plus a reset-abort sequence.
module tb_me_frame_scheduler;

  localparam int MAX_R = 2;
  localparam int SAD_W = 16;
  localparam int MV_W  = 7;
  localparam int MB_W  = 8;

  logic             clk;
  logic             reset;
  logic             frame_start;
  logic [MB_W-1:0]  mb_cols, mb_rows;
  logic [MAX_R-1:0] r_cfg;
  logic             me_go;
  logic [MAX_R-1:0] me_r;
  logic [15:0]      cur_base;
  logic             me_done, sad_valid;
  logic [SAD_W-1:0] sad_value;
  logic [MV_W-1:0]  sad_mvx, sad_mvy;
  logic             res_valid, res_ready;
  logic [MB_W-1:0]  res_mbx, res_mby;
  logic [SAD_W-1:0] res_sad;
  logic [MV_W-1:0]  res_mvx, res_mvy;
  logic             busy, frame_done;
`ifdef ME_SCHED_STATS_EN
  logic [SAD_W+15:0] frame_sad;
  logic [15:0]       mb_count;
`endif

  me_frame_scheduler #(
    .max_r(MAX_R), .SAD_W(SAD_W), .MV_W(MV_W), .MB_W(MB_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .mb_cols(mb_cols), .mb_rows(mb_rows), .r_cfg(r_cfg),
    .me_go(me_go), .me_r(me_r), .cur_base(cur_base),
    .me_done(me_done), .sad_valid(sad_valid), .sad_value(sad_value),
    .sad_mvx(sad_mvx), .sad_mvy(sad_mvy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mbx(res_mbx), .res_mby(res_mby), .res_sad(res_sad),
    .res_mvx(res_mvx), .res_mvy(res_mvy),
    .busy(busy), .frame_done(frame_done)
`ifdef ME_SCHED_STATS_EN
    , .frame_sad(frame_sad), .mb_count(mb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cols;
    int rows;
    int rng;
    int s[4];
    int inc;
    bit coinc;
    int stall;
  } vec_t;

  typedef struct {
    logic [MB_W-1:0]  mbx;
    logic [MB_W-1:0]  mby;
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  mvx;
    logic [MV_W-1:0]  mvy;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   errors = 0;
  int   checks = 0;
  int   fd_cnt = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int c, int r, int g, int a, int b, int d, int e,
                              int inc, bit coinc, int stall);
    vec_t v;
    v.cols = c; v.rows = r; v.rng = g;
    v.s[0] = a; v.s[1] = b; v.s[2] = d; v.s[3] = e;
    v.inc = inc; v.coinc = coinc; v.stall = stall;
    return v;
  endfunction

  function automatic logic [SAD_W-1:0] sad_of(vec_t v, int m, int k);
    return SAD_W'(v.s[k] + m * v.inc);
  endfunction
  function automatic logic [MV_W-1:0] mvx_of(int m, int k);
    return MV_W'(k * 5 - 7 + m);
  endfunction
  function automatic logic [MV_W-1:0] mvy_of(int m, int k);
    return MV_W'(3 - 2 * k - m);
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int      n;
    int      fd0;
    longint  sum;
    exp_t    e, got;
    n   = v.cols * v.rows;
    fd0 = fd_cnt;
    sum = 0;
    mb_cols = MB_W'(v.cols);
    mb_rows = MB_W'(v.rows);
    r_cfg   = MAX_R'(v.rng);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (n == 0) begin
      check($sformatf("v%0d zero me_go", vi), me_go, 0);
      check($sformatf("v%0d zero frame_done", vi), frame_done, 1);
      step();
      check($sformatf("v%0d zero frame_done pulse", vi), frame_done, 0);
      check($sformatf("v%0d zero busy", vi), busy, 0);
    end else begin
      for (int m = 0; m < n; m++) begin
        int mbx, mby, bk;
        logic [SAD_W-1:0] bs;
        mbx = m % v.cols;
        mby = m / v.cols;
        check($sformatf("v%0d m%0d me_go", vi, m), me_go, 1);
        check($sformatf("v%0d m%0d cur_base", vi, m), cur_base, 16'((mby * v.cols + mbx) * 32));
        check($sformatf("v%0d m%0d me_r", vi, m), me_r, v.rng);
        check($sformatf("v%0d m%0d busy", vi, m), busy, 1);
        bs = '1;
        bk = -1;
        for (int k = 0; k < 4; k++)
          if (sad_of(v, m, k) < bs) begin bs = sad_of(v, m, k); bk = k; end
        e.mbx = MB_W'(mbx);
        e.mby = MB_W'(mby);
        e.sad = bs;
        e.mvx = (bk < 0) ? '0 : mvx_of(m, bk);
        e.mvy = (bk < 0) ? '0 : mvy_of(m, bk);
        sb.push_back(e);
        sum += bs;
        res_ready = (v.stall == 0);
        step();
        check($sformatf("v%0d m%0d me_go pulse", vi, m), me_go, 0);
        for (int k = 0; k < 4; k++) begin
          sad_valid   = 1'b1;
          sad_value   = sad_of(v, m, k);
          sad_mvx     = mvx_of(m, k);
          sad_mvy     = mvy_of(m, k);
          me_done     = (k == 3) && v.coinc;
          frame_start = (k == 0);
          mb_cols     = MB_W'(v.cols + ((k == 0) ? 3 : 0));
          step();
        end
        frame_start = 1'b0;
        if (!v.coinc) begin
          sad_valid = 1'b0;
          me_done   = 1'b1;
          step();
        end
        sad_valid = 1'b0;
        me_done   = 1'b0;
        check($sformatf("v%0d m%0d res_valid", vi, m), res_valid, 1);
        if (sb.size() == 0) begin
          check($sformatf("v%0d m%0d scoreboard empty", vi, m), 1, 0);
        end else begin
          got = sb.pop_front();
          check($sformatf("v%0d m%0d res_mbx", vi, m), res_mbx, got.mbx);
          check($sformatf("v%0d m%0d res_mby", vi, m), res_mby, got.mby);
          check($sformatf("v%0d m%0d res_sad", vi, m), res_sad, got.sad);
          check($sformatf("v%0d m%0d res_mvx", vi, m), res_mvx, got.mvx);
          check($sformatf("v%0d m%0d res_mvy", vi, m), res_mvy, got.mvy);
          for (int s = 0; s < v.stall; s++) begin
            step();
            check($sformatf("v%0d m%0d stall%0d res_valid", vi, m, s), res_valid, 1);
            check($sformatf("v%0d m%0d stall%0d res_sad", vi, m, s), res_sad, got.sad);
            check($sformatf("v%0d m%0d stall%0d res_mvx", vi, m, s), res_mvx, got.mvx);
            check($sformatf("v%0d m%0d stall%0d res_mbx", vi, m, s), res_mbx, got.mbx);
            check($sformatf("v%0d m%0d stall%0d me_go", vi, m, s), me_go, 0);
          end
        end
        res_ready = 1'b1;
        step();
        check($sformatf("v%0d m%0d res_valid drop", vi, m), res_valid, 0);
        if (m == n - 1) begin
          check($sformatf("v%0d frame_done", vi), frame_done, 1);
          step();
          check($sformatf("v%0d frame_done pulse", vi), frame_done, 0);
          check($sformatf("v%0d idle busy", vi), busy, 0);
        end else begin
          check($sformatf("v%0d m%0d me_go early", vi, m), me_go, 0);
          check($sformatf("v%0d m%0d frame_done early", vi, m), frame_done, 0);
          step();
        end
      end
    end
    check($sformatf("v%0d frame_done count", vi), fd_cnt - fd0, 1);
`ifdef ME_SCHED_STATS_EN
    check($sformatf("v%0d frame_sad", vi), frame_sad, sum);
    check($sformatf("v%0d mb_count", vi), mb_count, n);
`endif
  endtask

  initial begin
    vt[0] = mk(2, 2, 1, 50, 20, 20, 30, 0, 0, 0);
    vt[1] = mk(1, 3, 2, 10, 40, 50, 60, 10, 0, 0);
    vt[2] = mk(3, 1, 3, 7, 9, 8, 3, 0, 1, 0);
    vt[3] = mk(1, 1, 0, 100, 90, 80, 70, 0, 0, 5);
    vt[4] = mk(0, 2, 1, 1, 2, 3, 4, 0, 0, 0);
    vt[5] = mk(3, 0, 2, 1, 2, 3, 4, 0, 0, 0);
    vt[6] = mk(2, 1, 1, 65535, 65535, 65535, 65535, 0, 0, 2);
    vt[7] = mk(5, 3, 2, 40, 12, 33, 12, 3, 1, 1);

    reset = 1'b0;
    frame_start = 1'b0;
    mb_cols = '0; mb_rows = '0; r_cfg = '0;
    me_done = 1'b0; sad_valid = 1'b0; sad_value = '0;
    sad_mvx = '0; sad_mvy = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset me_go", me_go, 0);
    check("reset busy", busy, 0);
    check("reset res_valid", res_valid, 0);
    check("reset res_sad", res_sad, 16'hFFFF);
    check("reset cur_base", cur_base, 0);
    check("reset frame_done", frame_done, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Abort mid-search: reset lands between edges, outputs must clear without a clock.
    mb_cols = 8'd2; mb_rows = 8'd2; r_cfg = 2'd1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    sad_valid = 1'b1; sad_value = 16'd5;
    step();
    sad_valid = 1'b0;
    check("abort busy before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort me_go", me_go, 0);
    check("abort busy", busy, 0);
    check("abort res_valid", res_valid, 0);
    check("abort res_sad", res_sad, 16'hFFFF);
    check("abort me_r", me_r, 0);
    check("abort cur_base", cur_base, 0);
    check("abort frame_done", frame_done, 0);
    step();
    check("abort held frame_done", frame_done, 0);
    reset = 1'b1;
    step();
    run_vec(vt[0], 8);

    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/me_frame_scheduler.md
# me_frame_scheduler

Frame-level sequencer for the motion-estimation datapath. Walks a frame macroblock by macroblock and launches one block search per macroblock on the search controller (`me_go` / `me_done`). Tracks the minimum SAD and its motion vector from the SAD stream, and hands one result per macroblock to the downstream writer over a valid/ready handshake. Sits between the host/frame-control registers and the search controller plus PE/comparator array.

## Interface
Parameters:
- `max_r`, 2: width of the search-range code.
- `SAD_W`, 16: SAD value width.
- `MV_W`, 7: signed motion-vector component width (two's complement).
- `MB_W`, 8: macroblock coordinate width.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `frame_start` input 1: starts a frame; sampled only in IDLE.
- `mb_cols` input MB_W: frame width in macroblocks; latched at `frame_start`.
- `mb_rows` input MB_W: frame height in macroblocks; latched at `frame_start`.
- `r_cfg` input max_r: search-range code; latched at `frame_start`.
- `me_go` output 1: one-cycle launch pulse to the search controller.
- `me_r` output max_r: latched range; stable from `me_go` until `me_done`.
- `cur_base` output 16: current-block word address, (mby*mb_cols+mbx)<<5.
- `me_done` input 1: one-cycle search-complete pulse.
- `sad_valid` input 1: candidate SAD present this cycle.
- `sad_value` input SAD_W: candidate SAD.
- `sad_mvx` input MV_W: candidate motion vector, x component.
- `sad_mvy` input MV_W: candidate motion vector, y component.
- `res_valid` output 1: result valid.
- `res_ready` input 1: downstream ready.
- `res_mbx` output MB_W: result macroblock column.
- `res_mby` output MB_W: result macroblock row.
- `res_sad` output SAD_W: best SAD for the macroblock.
- `res_mvx` output MV_W: best motion vector, x component.
- `res_mvy` output MV_W: best motion vector, y component.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse when a frame completes.

## Operation
States: IDLE, LAUNCH, WAIT, REPORT, NEXT, FDONE.
- **IDLE**: on `frame_start`, latch `mb_cols`, `mb_rows` and `r_cfg`, and clear mbx and mby.
  - If `mb_cols` or `mb_rows` is 0, go to FDONE.
  - Otherwise go to LAUNCH.
- **LAUNCH**:
  - `me_go`=1 for exactly this cycle.
  - Best SAD is set to all-ones; best MV is set to 0.
  - Go to WAIT.
- **WAIT**: each `sad_valid` with `sad_value` < best replaces best SAD and MV.
  - The comparison is strict, so the first candidate wins ties.
  - On `me_done` go to REPORT. A `sad_valid` in the same cycle as `me_done` is still included.
- **REPORT**: `res_*` are registered and hold stable while `res_valid`=1. Leave on `res_valid && res_ready`.
  - Go to NEXT if more macroblocks remain.
  - Go to FDONE after the last macroblock.
- **NEXT**: advance to the next macroblock, then go to LAUNCH.
  - If mbx < mb_cols-1, increment mbx.
  - Otherwise set mbx to 0 and increment mby.
- **FDONE**: `frame_done`=1 for one cycle, then go to IDLE.

Other rules:
- `frame_start` outside IDLE is ignored.
- `sad_valid` and `me_done` outside WAIT are ignored.
- Coordinate math:
  - `cur_base` is computed from the latched `mb_cols`; the product is truncated to 16 bits.
  - mbx and mby never exceed the latched limits.

## Timing
- Reset values:
  - All outputs are 0, except `res_sad`, which is all-ones.
  - State is IDLE.
  - Reset asserted mid-frame aborts immediately. No `frame_done` is issued; the frame must be restarted.
- Latencies:
  - `frame_start` sampled at edge N: `me_go` high in cycle N+1.
  - `me_done` at edge M: `res_valid` high from cycle M+1.
  - Handshake at edge K: next `me_go` in cycle K+2 (via NEXT), or `frame_done` in cycle K+1.
- Throughput: per-macroblock overhead beyond the search is 3 cycles plus any `res_ready` stall.
- `res_valid` is never deasserted without a handshake.

## Configuration
`ME_SCHED_STATS_EN`:
- **Defined**:
  - Adds output `frame_sad` [SAD_W+15:0], cleared at `frame_start`.
  - Each handshaked `res_sad` is added to it, saturating at all-ones.
  - Adds output `mb_count` [15:0], incremented per handshake.
  - Both values hold after `frame_done` until the next `frame_start`.
- **Undefined**: neither port nor register exists.

## Structure
- Shared parameters include holds:
  - the state encodings;
  - `SAD_W`, `MV_W`, `MB_W`;
  - the `cur_base` shift constant (5 = 32 words per 16x16 block).
- One sub-module, `me_best_tracker`:
  - holds best SAD and best MV;
  - inputs: `init`, `sad_valid`, `sad_value`, `sad_mvx`, `sad_mvy`.

## Test plan
- 2x2 frame, `res_ready`=1, each search sends SADs {50,20,20,30} -> 4 results with SAD 20 and the MV of the first 20; order (0,0),(1,0),(0,1),(1,1); `cur_base` 0,32,64,96; one `frame_done`.
- `mb_cols`=0 with `frame_start` -> no `me_go`; `frame_done` 1 cycle after the sample.
- `res_ready` low for 5 cycles in REPORT -> `res_*` stable; no new `me_go` until 2 cycles after the handshake.
- `sad_valid` with SAD 3 coincident with `me_done` -> `res_sad`=3.
- Reset asserted in WAIT -> all outputs at reset values asynchronously; new `frame_start` restarts at (0,0).
- `ME_SCHED_STATS_EN` defined, 1x3 frame with SADs 10,20,30 -> `frame_sad`=60, `mb_count`=3.
